temporal_cmp_bank: RTL and testbench

- N-channel, synchronous race-logic comparator bank for the space-time datapath.
- Each channel compares the arrival times of spike inputs a[i] and b[i] within a gamma cycle, using a per-cycle selectable mode: GE, LT, MIN or MAX.
- Each channel emits one regenerated PULSE_WIDTH-cycle output pulse plus a timestamp of the winning event.
- Successor to the single-channel pulse-width inhibit cell. Adds channel count, modes, timestamps and a saturating "infinity" horizon.

---
 rtl/temporal_pkg.sv | 12 +
 rtl/temporal_cmp_chan.sv | 60 ++++++
 rtl/temporal_cmp_bank.sv | 62 ++++++
 tb/tb_temporal_cmp_bank.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// temporal_pkg: comparison modes and sizing helpers shared by the race-logic comparator bank
package temporal_pkg;
  typedef enum logic [1:0] {
    CMP_GE  = 2'd0,
    CMP_LT  = 2'd1,
    CMP_MIN = 2'd2,
    CMP_MAX = 2'd3
  } cmp_mode_t;
  function automatic int pulse_cnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction
endpackage

// File: rtl/temporal_cmp_chan.sv
// temporal_cmp_chan: one race-logic channel with arrival/fired flags, event decode and pulse regeneration
module temporal_cmp_chan
  import temporal_pkg::*;
#(
  parameter int GW = 16,
  parameter int PW = 8
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          clr,
  input  logic          active,
  input  cmp_mode_t     mode,
  input  logic [GW-1:0] gamma_time,
  input  logic          a,
  input  logic          b,
  output logic          q,
  output logic          q_valid,
  output logic [GW-1:0] q_time
);
  localparam int CW = pulse_cnt_w(PW);
  logic a_arr_q, a_arr_d, b_arr_q, b_arr_d, fired_q, fired_d, q_valid_q, q_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] q_time_q, q_time_d;
  logic run, hit, ev;
  always_comb begin
    run = active && !clr;
    hit = mode == CMP_GE  ? a && !a_arr_q && !b_arr_q :
          mode == CMP_LT  ? a && !a_arr_q && !b_arr_q && !b :
          mode == CMP_MIN ? (a || b) && !a_arr_q && !b_arr_q :
                            (a || a_arr_q) && (b || b_arr_q);
    // the saturated horizon stands for "never": arrivals there are too late to win
    ev = run && gamma_time != '1 && !fired_q && hit;
    a_arr_d = !clr && (a_arr_q || (run && a));
    b_arr_d = !clr && (b_arr_q || (run && b));
    fired_d = !clr && (fired_q || ev);
    q_valid_d = !clr && (q_valid_q || ev);
    cnt_d = clr ? '0 : ev ? CW'(PW) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    q_time_d = clr ? '0 : ev ? gamma_time : q_time_q;
  end
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      a_arr_q <= 1'b0;
      b_arr_q <= 1'b0;
      fired_q <= 1'b0;
      q_valid_q <= 1'b0;
      cnt_q <= '0;
      q_time_q <= '0;
    end else begin
      a_arr_q <= a_arr_d;
      b_arr_q <= b_arr_d;
      fired_q <= fired_d;
      q_valid_q <= q_valid_d;
      cnt_q <= cnt_d;
      q_time_q <= q_time_d;
    end
  end
  assign q = cnt_q != '0;
  assign q_valid = q_valid_q;
  assign q_time = q_time_q;
endmodule

// File: rtl/temporal_cmp_bank.sv
// temporal_cmp_bank: N-channel race-logic comparator bank sharing one saturating gamma time base
module temporal_cmp_bank
  import temporal_pkg::*;
#(
  parameter int N_CH              = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                           aclk,
  input  logic                           grst,
  input  logic                           gamma_start,
  input  logic [1:0]                     mode,
  input  logic [N_CH-1:0]                a,
  input  logic [N_CH-1:0]                b,
  output logic [N_CH-1:0]                q,
  output logic [N_CH*GAMMA_CYCLE_WIDTH-1:0] q_time,
  output logic [N_CH-1:0]                q_valid,
  output logic [GAMMA_CYCLE_WIDTH-1:0]   gamma_time,
  output logic                           active
);
  localparam int GW = GAMMA_CYCLE_WIDTH;
  if (PULSE_WIDTH < 1) begin : g_pw_chk
    $error("PULSE_WIDTH must be >= 1");
  end
  logic [GW-1:0] gamma_time_q, gamma_time_d;
  logic active_q, active_d;
  cmp_mode_t mode_q, mode_d;
  always_comb begin
    gamma_time_d = gamma_start ? '0 :
                   active_q && gamma_time_q != '1 ? gamma_time_q + GW'(1) : gamma_time_q;
    active_d = active_q || gamma_start;
    mode_d = gamma_start ? cmp_mode_t'(mode) : mode_q;
  end
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      gamma_time_q <= '0;
      active_q <= 1'b0;
      mode_q <= CMP_GE;
    end else begin
      gamma_time_q <= gamma_time_d;
      active_q <= active_d;
      mode_q <= mode_d;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    temporal_cmp_chan #(.GW(GW), .PW(PULSE_WIDTH)) u_chan (
      .aclk      (aclk),
      .grst      (grst),
      .clr       (gamma_start),
      .active    (active_q),
      .mode      (mode_q),
      .gamma_time(gamma_time_q),
      .a         (a[i]),
      .b         (b[i]),
      .q         (q[i]),
      .q_valid   (q_valid[i]),
      .q_time    (q_time[i*GW +: GW])
    );
  end
  assign gamma_time = gamma_time_q;
  assign active = active_q;
endmodule

// File: tb/tb_temporal_cmp_bank.sv
// tb_temporal_cmp_bank: directed checks of modes, ties, inhibit, saturation, restart and reset
module tb_temporal_cmp_bank;
  localparam int N = 8, GW = 4, PW = 8;
  logic aclk = 1'b0, grst = 1'b1, gamma_start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [N-1:0] a = '0, b = '0, q, q_valid;
  logic [N*GW-1:0] q_time;
  logic [GW-1:0] gamma_time;
  logic active;
  int n_chk = 0, n_fail = 0;

  temporal_cmp_bank #(.N_CH(N), .GAMMA_CYCLE_WIDTH(GW), .PULSE_WIDTH(PW)) dut (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .mode(mode), .a(a), .b(b),
    .q(q), .q_time(q_time), .q_valid(q_valid), .gamma_time(gamma_time), .active(active)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  // b is driven high in the start cycle to prove it is ignored; mode is flipped afterwards to prove it is latched
  task automatic start(input logic [1:0] m);
    mode = m;
    gamma_start = 1'b1;
    a = '0;
    b = '1;
    step;
    gamma_start = 1'b0;
    b = '0;
    mode = ~m;
    chk("start_time", 64'(gamma_time), 64'd0);
    chk("start_active", 64'(active), 64'd1);
    chk("start_q", 64'(q), 64'd0);
    chk("start_valid", 64'(q_valid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] m, input int ta, input int tb, input int te);
    start(m);
    for (int t = 0; t < 26; t++) begin
      a[0] = ta >= 0 && t >= ta && t < ta + 20;
      b[0] = tb >= 0 && t >= tb && t < tb + 20;
      step;
      chk({tag, "_q"}, 64'(q), (te >= 0 && t >= te && t < te + PW) ? 64'd1 : 64'd0);
      chk({tag, "_valid"}, 64'(q_valid), (te >= 0 && t >= te) ? 64'd1 : 64'd0);
      if (te >= 0 && t >= te) chk({tag, "_time"}, 64'(q_time), 64'(te));
      chk({tag, "_gt"}, 64'(gamma_time), t + 1 > 15 ? 64'd15 : 64'(t + 1));
    end
    a = '0;
    b = '0;
  endtask

  initial begin
    repeat (3) step;
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_valid", 64'(q_valid), 64'd0);
    chk("rst_time", 64'(q_time), 64'd0);
    chk("rst_gt", 64'(gamma_time), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    grst = 1'b0;
    step;
    start(2'd0);
    a[0] = 1'b1;
    step;
    chk("pre_rst_q", 64'(q), 64'd1);
    #1 grst = 1'b1;
    #1;
    chk("async_rst_q", 64'(q), 64'd0);
    chk("async_rst_valid", 64'(q_valid), 64'd0);
    chk("async_rst_active", 64'(active), 64'd0);
    step;
    grst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 8'hA5 ^ 8'(i * 37);
      b = ~a;
      step;
      chk("idle_q", 64'(q), 64'd0);
      chk("idle_valid", 64'(q_valid), 64'd0);
      chk("idle_active", 64'(active), 64'd0);
    end
    a = '0;
    b = '0;
    run("ge_tie", 2'd0, 5, 5, 5);
    run("lt_tie", 2'd1, 5, 5, -1);
    run("ge_inhibit", 2'd0, 7, 3, -1);
    run("ge_pass", 2'd0, 3, 7, 3);
    run("min", 2'd2, 4, 9, 4);
    run("max", 2'd3, 4, 9, 9);
    run("sat_inf", 2'd0, 15, -1, -1);
    run("sat_edge", 2'd0, 14, -1, 14);
    start(2'd0);
    step;
    step;
    a[0] = 1'b1;
    step;
    chk("rs_q", 64'(q), 64'd1);
    chk("rs_time", 64'(q_time), 64'd2);
    a[0] = 1'b0;
    step;
    step;
    chk("rs_mid_q", 64'(q), 64'd1);
    mode = 2'd0;
    gamma_start = 1'b1;
    step;
    gamma_start = 1'b0;
    chk("rs_trunc_q", 64'(q), 64'd0);
    chk("rs_trunc_valid", 64'(q_valid), 64'd0);
    chk("rs_trunc_gt", 64'(gamma_time), 64'd0);
    step;
    chk("rs_after_q", 64'(q), 64'd0);
    start(2'd0);
    step;
    a = '1;
    step;
    chk("all_q", 64'(q), 64'hFF);
    chk("all_valid", 64'(q_valid), 64'hFF);
    chk("all_time", 64'(q_time), 64'h11111111);
    for (int i = 1; i < PW; i++) begin
      step;
      chk("all_hold_q", 64'(q), 64'hFF);
    end
    step;
    chk("all_end_q", 64'(q), 64'd0);
    chk("all_end_valid", 64'(q_valid), 64'hFF);
    chk("all_end_time", 64'(q_time), 64'h11111111);
    a = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
